demux_1_2_12bit_stream: RTL
===========================

// Module: demux_1_2_12bit_stream
// PURPOSE
//  Buffered 1-to-2 demultiplexer. It is the inverse of the 12-bit 2:1 residue select mux.
//  It steers a 12-bit word from one valid/ready input stream to channel A (sel=0) or channel B (sel=1).
//  Each channel has its own FIFO, so a stalled channel never corrupts or reorders the other.
//  Sits between the RNS forward-conversion stage and the two residue datapaths.
// PARAMETERS
//  WIDTH  12  data width in bits
//  DEPTH  4   per-channel FIFO depth in words; power of two, >= 2
//  CW     3   occupancy counter width; must equal clog2(DEPTH+1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  in_data    in   WIDTH  input word
//  in_sel     in   1      destination: 0 -> channel A, 1 -> channel B
//  in_valid   in   1      input word and in_sel are valid
//  in_ready   out  1      block accepts the input word this cycle
//  a_data     out  WIDTH  channel A head word
//  a_valid    out  1      channel A head word valid
//  a_ready    in   1      channel A consumer accepts the head word
//  b_data     out  WIDTH  channel B head word
//  b_valid    out  1      channel B head word valid
//  b_ready    in   1      channel B consumer accepts the head word
//  a_count    out  CW     channel A occupancy, 0..DEPTH
//  b_count    out  CW     channel B occupancy, 0..DEPTH
// BEHAVIOUR
//  Clocking and reset
//  - One clock domain. Reset is synchronous and active-high.
//  - While rst=1 at a clk edge: both FIFOs are cleared (pointers and counts to 0).
//  - Reset values: a_valid=b_valid=0, a_count=b_count=0, a_data=b_data=0.
//  - in_ready is held 0 in the cycle rst is high.
//  - Reset mid-operation discards all buffered words. No output handshake completes in that cycle.
//  Input handshake
//  - in_ready = ~rst & (in_sel ? ~full_B : ~full_A).
//  - in_ready is combinational from in_sel and registered full flags only.
//  - There is no path from a_ready or b_ready to in_ready.
//  - Push happens when in_valid & in_ready: in_data is written to the tail of the selected FIFO.
//  - in_data and in_sel must stay stable while in_valid=1 and in_ready=0.
//  Output handshake (each channel independent)
//  - x_valid = (x_count != 0).
//  - x_data = head word when x_valid=1; x_data = 0 when x_valid=0.
//  - Pop happens when x_valid & x_ready: the head advances at that clk edge.
//  - Latency: a word pushed into an empty FIFO at edge N gives x_valid=1 in the cycle after edge N.
//  - Strict FIFO order is kept per channel. There is no ordering guarantee across channels.
//  Boundary conditions
//  - Full FIFO, push and pop in the same cycle: the push is blocked because in_ready=0.
//    The pop completes and count goes DEPTH -> DEPTH-1.
//  - Non-full, non-empty FIFO, push and pop in the same cycle: count is unchanged and both pointers advance.
//  - Empty FIFO with push: no same-cycle bypass. x_valid rises only on the next cycle.
//  - Pointers wrap modulo DEPTH. Counts never exceed DEPTH and never underflow.
//  - x_ready while x_valid=0 is ignored.
//  - A full channel does not stall words destined for the other channel.
// TESTING
//  1 Reset: after rst=1 for 2 cycles, expect a_valid=b_valid=0, counts=0, a_data=b_data=0, in_ready=1.
//  2 Routing: push 0x123 (sel=0), then 0xABC (sel=1).
//    Expect a_data=0x123, b_data=0xABC, each one cycle after its push; a_count=b_count=1.
//  3 Full/backpressure: a_ready=0, push 4 words sel=0 -> a_count=4 and in_ready=0 for sel=0.
//    A sel=1 word is still accepted while channel A is full.
//  4 Simultaneous: a_count=2, push sel=0 and pop A in the same cycle -> a_count stays 2 and order is preserved.
//    With a_count=4, a pop plus a held push -> the push is accepted the next cycle.
//  5 Wrap: stream 10 words 0x001..0x00A to B with random b_ready.
//    Expect the output sequence 0x001..0x00A in order, with no loss or duplication.
//  6 Mid-op reset: with a_count=3 and b_count=2, assert rst for one cycle.
//    Both counts go to 0 and valids go to 0 the next cycle, and no stale word reappears.

Source files
------------

// File: rtl/demux_1_2_12bit_stream.sv
// Buffered 1-to-2 demultiplexer for 12-bit residue words.
// Each input word is steered by in_sel into a private FIFO, either channel A or channel B.
// Because each channel has its own FIFO, backpressure on one output never blocks
// or reorders traffic headed for the other output.

// Per-channel FIFO: circular buffer with a registered occupancy count.
module demux_1_2_12bit_stream_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop_req,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic                        pop;

  // DEPTH is a power of two, so the pointers wrap on their own.
  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = pop_req & valid;
  assign rdata = valid ? mem[rptr] : '0;

  // Pointer, storage and occupancy update. A reset discards the contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Top level: input steering, plus one FIFO instance for each channel.
module demux_1_2_12bit_stream #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CW-1:0]    a_count,
  output logic [CW-1:0]    b_count
);
  localparam int NCH = 2;

  logic [NCH-1:0]            ch_push, ch_pop_req, ch_valid, ch_full;
  logic [NCH-1:0][WIDTH-1:0] ch_rdata;
  logic [NCH-1:0][CW-1:0]    ch_count;

  // Readiness depends only on in_sel and the registered full flags,
  // so there is no combinational path from a_ready or b_ready.
  assign in_ready      = ~rst & (in_sel ? ~ch_full[1] : ~ch_full[0]);
  assign ch_push[0]    = in_valid & in_ready & ~in_sel;
  assign ch_push[1]    = in_valid & in_ready &  in_sel;
  assign ch_pop_req[0] = a_ready;
  assign ch_pop_req[1] = b_ready;

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      demux_1_2_12bit_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (ch_push[g]),
        .wdata   (in_data),
        .pop_req (ch_pop_req[g]),
        .rdata   (ch_rdata[g]),
        .valid   (ch_valid[g]),
        .full    (ch_full[g]),
        .count   (ch_count[g])
      );
    end
  endgenerate

  assign a_data  = ch_rdata[0];
  assign a_valid = ch_valid[0];
  assign a_count = ch_count[0];
  assign b_data  = ch_rdata[1];
  assign b_valid = ch_valid[1];
  assign b_count = ch_count[1];
endmodule
